// File: rtl/uart_echo_engine_pkg.sv
// Shared types and helpers for the UART echo engine: transform modes,
// line-terminator constants and the per-byte character transform.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_LOWER  = 2'd3
    } mode_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    function automatic logic is_line_end(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

    // Letters differ from their other case only in bit 5.
    function automatic logic [7:0] to_transformed(input logic [7:0] b, input mode_t m);
        logic       is_upper;
        logic       is_lower;
        logic [7:0] r;
        is_upper = (b >= 8'h41) && (b <= 8'h5A);
        is_lower = (b >= 8'h61) && (b <= 8'h7A);
        r        = b;
        case (m)
            MODE_INVERT: if (is_upper || is_lower) r[5] = ~b[5];
            MODE_UPPER:  if (is_lower) r[5] = 1'b0;
            MODE_LOWER:  if (is_upper) r[5] = 1'b1;
            default:     r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_echo_engine_if.sv
// Byte-stream handshake bundle: UART receiver bytes in, AXI-Stream bytes out.
interface uart_echo_engine_if;
    logic       s_axis_tvalid;
    logic [7:0] s_axis_tdata;
    logic       m_axis_tready;
    logic       m_axis_tvalid;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tlast;

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/uart_echo_engine_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module sdp_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     sresetn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) rdata <= '0;
        else          rdata <= mem[raddr];
    end
endmodule

// File: rtl/uart_echo_engine.sv
// Echo/transform stage: transforms incoming bytes, buffers them in a FIFO with
// an optional line-commit gate, and keeps saturating rx/drop statistics.
module uart_echo_engine #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 sresetn,
    input  logic [1:0]           mode,
    input  logic                 line_mode,
    input  logic                 clear_stats,
    uart_echo_engine_if.slave    axis,
    output logic [CNT_WIDTH-1:0] rx_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 overflow
);
    import uart_echo_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic          s1_valid;
    logic [7:0]    s1_data;
    logic          s1_eol;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] occupancy, span_next, rd_next;
    logic          handshake, accept, write, forced, wr_last;
    logic [8:0]    rdata;

    always_comb begin
        handshake = axis.m_axis_tvalid & axis.m_axis_tready;
        occupancy = wr_ptr - rd_ptr;
        accept    = (occupancy < DEPTH_P) | handshake;
        write     = s1_valid & accept;
        span_next = wr_ptr + PW'(1) - commit_ptr;
        forced    = line_mode & (span_next == DEPTH_P);
        wr_last   = s1_eol | forced;
        rd_next   = rd_ptr + PW'(handshake);
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_eol   <= 1'b0;
        end else begin
            s1_valid <= axis.s_axis_tvalid;
            s1_data  <= to_transformed(axis.s_axis_tdata, mode_t'(mode));
            s1_eol   <= is_line_end(axis.s_axis_tdata);
        end
    end

    // The read stage always fetches RAM[rd_next]; validity compares against the
    // pre-edge commit_ptr so a byte is only shown once its RAM write has landed.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            wr_ptr             <= '0;
            commit_ptr         <= '0;
            rd_ptr             <= '0;
            axis.m_axis_tvalid <= 1'b0;
        end else begin
            if (write) wr_ptr <= wr_ptr + PW'(1);
            if (!line_mode)
                commit_ptr <= wr_ptr + PW'(write);
            else if (write && wr_last)
                commit_ptr <= wr_ptr + PW'(1);
            rd_ptr             <= rd_next;
            axis.m_axis_tvalid <= (rd_next != commit_ptr);
        end
    end

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            rx_count   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear_stats) begin
            rx_count   <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (axis.s_axis_tvalid && (rx_count != '1))
                rx_count <= rx_count + 1'b1;
            if (s1_valid && !accept) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end

    sdp_ram #(.DEPTH(DEPTH), .WIDTH(9)) u_ram (
        .clk     (clk),
        .sresetn (sresetn),
        .we      (write),
        .waddr   (wr_ptr[AW-1:0]),
        .wdata   ({wr_last, s1_data}),
        .raddr   (rd_next[AW-1:0]),
        .rdata   (rdata)
    );

    assign axis.m_axis_tdata = rdata[7:0];
    assign axis.m_axis_tlast = rdata[8];
endmodule

// File: tb/tb_uart_echo_engine.sv
// Bench for uart_echo_engine: transform vector table, directed corner-case
// sequences and a random run against a queue-based reference model.
module tb_uart_echo_engine;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_WIDTH = 10;
    localparam int unsigned CMAX      = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 sresetn = 1'b0;
    logic [1:0]           mode = 2'd0;
    logic                 line_mode = 1'b0;
    logic                 clear_stats = 1'b0;
    logic [CNT_WIDTH-1:0] rx_count, drop_count;
    logic                 overflow;

    uart_echo_engine_if axis();

    uart_echo_engine #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk         (clk),
        .sresetn     (sresetn),
        .mode        (mode),
        .line_mode   (line_mode),
        .clear_stats (clear_stats),
        .axis        (axis),
        .rx_count    (rx_count),
        .drop_count  (drop_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_xform(input logic [7:0] b, input logic [1:0] m);
        logic is_up, is_lo;
        is_up = (b >= 8'd65) && (b <= 8'd90);
        is_lo = (b >= 8'd97) && (b <= 8'd122);
        case (m)
            2'd1:    return is_up ? b + 8'd32 : (is_lo ? b - 8'd32 : b);
            2'd2:    return is_lo ? b - 8'd32 : b;
            2'd3:    return is_up ? b + 8'd32 : b;
            default: return b;
        endcase
    endfunction

    // Reference model: stored bytes in a queue, plus how many of them are released.
    typedef struct packed { logic [7:0] d; logic l; } ent_t;
    ent_t        mq[$];
    int          m_ncommit;
    bit          m_valid;
    bit          m_s1v;
    logic [7:0]  m_s1d;
    bit          m_s1e;
    int unsigned m_rx, m_drop;
    bit          m_ovf;

    always @(posedge clk or negedge sresetn) begin : model
        bit hs, acc, wr, frc, last;
        int unc, nc_old;
        if (!sresetn) begin
            mq.delete();
            m_ncommit = 0; m_valid = 0; m_s1v = 0; m_s1d = '0; m_s1e = 0;
            m_rx = 0; m_drop = 0; m_ovf = 0;
        end else begin
            hs     = m_valid && axis.m_axis_tready;
            acc    = (mq.size() < DEPTH) || hs;
            wr     = m_s1v && acc;
            nc_old = m_ncommit;
            unc    = mq.size() - m_ncommit;
            if (hs) begin
                void'(mq.pop_front());
                m_ncommit--;
            end
            if (wr) begin
                frc  = line_mode && (unc + 1 == DEPTH);
                last = m_s1e || frc;
                mq.push_back({m_s1d, last});
                if (line_mode && last) m_ncommit = mq.size();
            end
            if (!line_mode) m_ncommit = mq.size();
            m_valid = (nc_old - int'(hs)) > 0;
            if (clear_stats) begin
                m_rx = 0; m_drop = 0; m_ovf = 0;
            end else begin
                if (axis.s_axis_tvalid && m_rx < CMAX) m_rx++;
                if (m_s1v && !acc) begin
                    m_ovf = 1;
                    if (m_drop < CMAX) m_drop++;
                end
            end
            m_s1v = axis.s_axis_tvalid;
            m_s1d = ref_xform(axis.s_axis_tdata, mode);
            m_s1e = (axis.s_axis_tdata == 8'h0A) || (axis.s_axis_tdata == 8'h0D);
        end
    end

    always @(negedge clk) begin
        if (chk_on && sresetn) begin
            check("m_tvalid", axis.m_axis_tvalid, m_valid);
            if (m_valid && mq.size() > 0) begin
                check("m_tdata", axis.m_axis_tdata, mq[0].d);
                check("m_tlast", axis.m_axis_tlast, mq[0].l);
            end
            check("m_rx_count", rx_count, m_rx);
            check("m_drop_count", drop_count, m_drop);
            check("m_overflow", overflow, m_ovf);
        end
    end

    logic [8:0] got[$];
    always @(negedge clk) begin
        if (sresetn && axis.m_axis_tvalid && axis.m_axis_tready)
            got.push_back({axis.m_axis_tlast, axis.m_axis_tdata});
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        axis.s_axis_tvalid = 1'b1;
        axis.s_axis_tdata  = b;
        tick();
        axis.s_axis_tvalid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
    endtask

    task automatic check_got(input string name, input logic [8:0] exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check($sformatf("%s_%0d", name, i), (i < got.size()) ? got[i] : 9'h1FF, exp[i]);
    endtask

    typedef struct { logic [1:0] m; logic [7:0] din; logic [7:0] dout; } vec_t;
    vec_t vt[13];

    initial begin
        logic [8:0] exp_q[$];
        axis.s_axis_tvalid = 1'b0;
        axis.s_axis_tdata  = '0;
        axis.m_axis_tready = 1'b0;

        tick(3);
        check("rst_tvalid", axis.m_axis_tvalid, 0);
        check("rst_tdata", axis.m_axis_tdata, 0);
        check("rst_tlast", axis.m_axis_tlast, 0);
        check("rst_rx", rx_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ovf", overflow, 0);
        sresetn = 1'b1;
        chk_on  = 1'b1;
        tick();

        // Letter boundaries: '@' 'A' 'Z' '[' '`' 'a' 'z' '{' around each case range.
        vt[0]  = '{2'd1, 8'h40, 8'h40};
        vt[1]  = '{2'd1, 8'h41, 8'h61};
        vt[2]  = '{2'd1, 8'h5A, 8'h7A};
        vt[3]  = '{2'd1, 8'h5B, 8'h5B};
        vt[4]  = '{2'd1, 8'h60, 8'h60};
        vt[5]  = '{2'd1, 8'h61, 8'h41};
        vt[6]  = '{2'd1, 8'h7A, 8'h5A};
        vt[7]  = '{2'd1, 8'h7B, 8'h7B};
        vt[8]  = '{2'd2, 8'h6D, 8'h4D};
        vt[9]  = '{2'd2, 8'h4D, 8'h4D};
        vt[10] = '{2'd3, 8'h51, 8'h71};
        vt[11] = '{2'd3, 8'h71, 8'h71};
        vt[12] = '{2'd0, 8'h6B, 8'h6B};
        for (int i = 0; i < 13; i++) begin
            mode = vt[i].m;
            send(vt[i].din);
            tick();
            check($sformatf("vec%0d_early", i), axis.m_axis_tvalid, 0);
            tick();
            check($sformatf("vec%0d_tvalid", i), axis.m_axis_tvalid, 1);
            check($sformatf("vec%0d_tdata", i), axis.m_axis_tdata, vt[i].dout);
            check($sformatf("vec%0d_tlast", i), axis.m_axis_tlast, 0);
            axis.m_axis_tready = 1'b1;
            tick();
            axis.m_axis_tready = 1'b0;
        end

        // Stream INVERT "aB3z" at full rate.
        got.delete();
        mode = 2'd1;
        axis.m_axis_tready = 1'b1;
        send("a");
        check("inv_lat0", axis.m_axis_tvalid, 0);
        send("B");
        check("inv_lat1", axis.m_axis_tvalid, 0);
        send("3");
        check("inv_lat2", axis.m_axis_tvalid, 1);
        check("inv_first", axis.m_axis_tdata, 8'h41);
        send("z");
        tick(4);
        exp_q = '{9'h041, 9'h062, 9'h033, 9'h05A};
        check_got("inv_out", exp_q);

        // Line mode UPPER: "hi" held until LF.
        got.delete();
        line_mode = 1'b1;
        mode = 2'd2;
        tick();
        send("h");
        send("i");
        tick(3);
        check("line_hold", axis.m_axis_tvalid, 0);
        send(8'h0A);
        check("line_lf0", axis.m_axis_tvalid, 0);
        tick();
        check("line_lf1", axis.m_axis_tvalid, 0);
        tick();
        check("line_lf2", axis.m_axis_tvalid, 1);
        tick(4);
        exp_q = '{9'h048, 9'h049, 9'h10A};
        check_got("line_out", exp_q);

        // Forced commit: 6 bytes, no terminator, output stalled.
        axis.m_axis_tready = 1'b0;
        mode = 2'd0;
        pulse_clear();
        send("a"); send("b"); send("c"); send("d"); send("e"); send("f");
        tick(2);
        check("force_drop", drop_count, 2);
        check("force_ovf", overflow, 1);
        check("force_rx", rx_count, 6);
        check("force_tvalid", axis.m_axis_tvalid, 1);
        got.delete();
        axis.m_axis_tready = 1'b1;
        tick(6);
        axis.m_axis_tready = 1'b0;
        exp_q = '{9'h061, 9'h062, 9'h063, 9'h164};
        check_got("force_out", exp_q);

        // Full FIFO: read and write on the same edge.
        line_mode = 1'b0;
        pulse_clear();
        send("1"); send("2"); send("3"); send("4");
        tick(2);
        got.delete();
        send("5");
        axis.m_axis_tready = 1'b1;
        tick();
        axis.m_axis_tready = 1'b0;
        tick();
        check("full_rw_drop", drop_count, 0);
        send("6");
        tick();
        check("full_still_full", drop_count, 1);
        axis.m_axis_tready = 1'b1;
        tick(6);
        axis.m_axis_tready = 1'b0;
        exp_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035};
        check_got("full_out", exp_q);

        // Reset with committed bytes pending.
        send("p"); send("q"); send("r");
        tick(3);
        check("pre_rst_tvalid", axis.m_axis_tvalid, 1);
        sresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", axis.m_axis_tvalid, 0);
        check("mid_rst_rx", rx_count, 0);
        tick();
        sresetn = 1'b1;
        tick();
        got.delete();
        axis.m_axis_tready = 1'b1;
        send("x");
        tick(5);
        exp_q = '{9'h078};
        check_got("post_rst_out", exp_q);

        // Counter saturation, then clear coinciding with a drop.
        pulse_clear();
        for (int i = 0; i < CMAX; i++) send(8'($urandom_range(32, 126)));
        tick();
        check("rx_at_max", rx_count, CMAX);
        send("s");
        tick();
        check("rx_hold", rx_count, CMAX);
        axis.m_axis_tready = 1'b0;
        tick(3);
        pulse_clear();
        send("A"); send("B"); send("C"); send("D");
        tick(2);
        send("y");
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("clr_drop", drop_count, 0);
        check("clr_ovf", overflow, 0);
        check("clr_rx", rx_count, 0);
        send("z");
        tick();
        check("after_clr_drop", drop_count, 1);
        check("after_clr_ovf", overflow, 1);
        check("after_clr_rx", rx_count, 1);
        axis.m_axis_tready = 1'b1;
        tick(6);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int pick;
            pick = int'($urandom_range(0, 9));
            axis.s_axis_tvalid = ($urandom_range(0, 3) != 0);
            axis.s_axis_tdata  = (pick == 0) ? 8'h0A : (pick == 1) ? 8'h0D : 8'($urandom_range(0, 255));
            axis.m_axis_tready = ($urandom_range(0, 2) != 0);
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) line_mode = ~line_mode;
            clear_stats = ($urandom_range(0, 99) == 0);
            tick();
        end
        axis.s_axis_tvalid = 1'b0;
        clear_stats = 1'b0;
        line_mode = 1'b0;
        axis.m_axis_tready = 1'b1;
        tick(12);
        check("final_empty", axis.m_axis_tvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_echo_engine.md
# uart_echo_engine

Parametrised echo/transform stage between a UART receiver's byte stream and a UART transmitter's AXI-Stream input. It applies a runtime-selectable character transform (pass, case-invert, force-upper, force-lower) and buffers bytes in an internal FIFO. It can hold output until a line terminator arrives (line mode). It keeps saturating receive and drop counters plus a sticky overflow flag for LED/debug display.

## Interface
- DEPTH, 1024: FIFO entries; power of two, ≥4.
- CNT_WIDTH, 16: width of statistics counters.
- clk  in  1  single clock; all logic on rising edge.
- sresetn  in  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream.
- mode  in  2  transform select (see package enum); sampled per byte at input acceptance.
- line_mode  in  1  1 = release bytes only at line end; 0 = stream.
- clear_stats  in  1  single-cycle pulse; zeroes counters and overflow flag.
- s_axis_tvalid  in  1  input byte strobe; no backpressure (source is a UART receiver).
- s_axis_tdata  in  8  input byte.
- m_axis_tready  in  1  output ready.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  8  transformed byte.
- m_axis_tlast  out  1  high on a byte that is CR or LF, or on the last byte of a forced commit.
- rx_count  out  CNT_WIDTH  bytes seen on input, saturating.
- drop_count  out  CNT_WIDTH  bytes discarded because FIFO full, saturating.
- overflow  out  1  sticky; set on first drop.

## Operation
- Transform, combinational on the input byte, result registered (stage S1):
  - PASS: unchanged.
  - INVERT: 'A'–'Z' ↔ 'a'–'z' via bit 5 flip, applied only when the byte is a letter.
  - UPPER: clear bit 5 for 'a'–'z' only.
  - LOWER: set bit 5 for 'A'–'Z' only.
  - All non-letters pass unchanged.
- FIFO pointers: wr_ptr, commit_ptr, rd_ptr, each log2(DEPTH)+1 bits; wrap by natural overflow. occupancy = wr_ptr − rd_ptr.
- Write from S1 accepted if occupancy < DEPTH, or a read handshake occurs on the same edge. Otherwise the byte is dropped: drop_count+1, overflow←1.
- Output is valid when rd_ptr ≠ commit_ptr. Data comes from a registered read stage (first-word fall-through).
- Stream mode: commit_ptr follows wr_ptr (commit on each write).
- Line mode, two states:
  - FILL: writes do not advance commit_ptr.
  - A written CR (8'h0D) or LF (8'h0A) sets commit_ptr ← wr_ptr+1 (terminator included).
  - Uncommitted span reaching DEPTH forces a commit of all written bytes; that last byte carries tlast.
  - DRAIN is implicit: reads proceed while rd_ptr ≠ commit_ptr, while FILL continues concurrently.
- line_mode 1→0: commit_ptr ← wr_ptr on the next edge.
- line_mode 0→1: already-committed bytes still drain.
- rx_count increments on every s_axis_tvalid, including dropped bytes. Both counters hold at all-ones.
- clear_stats zeroes counters and overflow. Simultaneous event on the same edge: the clear wins, and the event is not counted.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, rx_count=0, drop_count=0, overflow=0. All pointers 0 and FIFO contents discarded.
- Reset mid-operation clears everything immediately. No partial line survives.
- Stream mode, empty FIFO:
  - byte sampled at edge k;
  - written at edge k+1;
  - m_axis_tvalid high after edge k+2.
- Line mode: tvalid rises 2 edges after the terminator is sampled.
- Handshake: transfer when tvalid & tready at an edge. tvalid never drops without a transfer. tdata/tlast are stable while tvalid & !tready.
- Sustained throughput is 1 byte/cycle in and out.

## Structure
- Package uart_echo_pkg holds:
  - mode enum (MODE_PASS=0, MODE_INVERT=1, MODE_UPPER=2, MODE_LOWER=3);
  - CHAR_CR, CHAR_LF constants;
  - a function to_transformed(byte, mode).
- One sub-module, sdp_ram: simple dual-port DEPTH×9 (data+tlast), registered read. The engine owns pointers and control.

## Test plan
- Stream, mode=INVERT, input "aB3z" → output "Ab3Z", tlast=0 throughout, first tvalid 2 cycles after 'a'.
- Line mode, mode=UPPER, input "hi" then LF with tready=1 → no tvalid until 2 edges after LF; output 'H','I',0x0A, tlast only on 0x0A.
- DEPTH=4, line mode, 6 bytes without terminator, tready=0:
  - 4 stored, forced commit, 4th byte tlast=1;
  - drop_count=2, overflow=1, rx_count=6.
- Full FIFO with a read and a write on the same edge → write accepted, drop_count unchanged, occupancy stays DEPTH.
- Reset asserted while 3 committed bytes are pending → tvalid=0 immediately; after release, new byte 'x' in stream PASS emerges alone.
- rx_count preloaded by 65535 inputs (CNT_WIDTH=16), one more byte → holds 0xFFFF; clear_stats same edge as a drop → counters 0, overflow 0.
